// File: rtl/fht_pkg.sv
// Shared FHT definitions: frame-loader state encoding and a width-generic bit-reversal helper.
package fht_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FILL    = 3'd1,
        FLUSH   = 3'd2,
        KICK    = 3'd3,
        WAIT_LO = 3'd4,
        WAIT_HI = 3'd5,
        DONE    = 3'd6
    } loader_state_t;

    // Reverses the low 'width' bits of val; bits at and above 'width' come back as zero.
    function automatic logic [31:0] bitrev(input logic [31:0] val, input int width);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 32; i++) begin
            if (i < width) begin
                r[i] = val[width - 1 - i];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/fht_bitrev_addr.sv
// Maps a linear sample index to a bank strobe and in-bank address, natural or bit-reversed.
// Purely combinational so the readout/unscramble path can share it.
module fht_bitrev_addr
    import fht_pkg::*;
#(
    parameter int A_BIT   = 8,
    parameter int NB_LOG2 = 2
) (
    input  logic [A_BIT+NB_LOG2-1:0] k,
    input  logic                     mode,
    output logic [(1<<NB_LOG2)-1:0]  bank_we,
    output logic [A_BIT-1:0]         addr
);

    localparam int NB  = 1 << NB_LOG2;
    localparam int IDX = A_BIT + NB_LOG2;

    logic [IDX-1:0] j;

    // Low index bits pick the bank, high bits the word within it.
    always_comb begin
        if (mode) begin
            j = IDX'(bitrev(32'(k), IDX));
        end else begin
            j = k;
        end
        bank_we = {{(NB-1){1'b0}}, 1'b1} << j[NB_LOG2-1:0];
        addr    = j[IDX-1:NB_LOG2];
    end

endmodule

// File: rtl/fht_bank_loader.sv
// Frame loader: scatters one N-point sample stream across NB banks, then optionally
// launches fht_top and waits for its ready handshake before reporting done.
module fht_bank_loader
    import fht_pkg::*;
#(
    parameter int D_BIT      = 16,
    parameter int A_BIT      = 8,
    parameter int NB_LOG2    = 2,
    parameter int AUTO_START = 1
) (
    input  logic                    iCLK,
    input  logic                    iRESET,
    input  logic                    iLOAD,
    input  logic                    iBITREV,
    input  logic [D_BIT-1:0]        iDATA,
    input  logic                    iVALID,
    output logic                    oREADY,
    output logic [(1<<NB_LOG2)-1:0] oWE,
    output logic [A_BIT-1:0]        oADDR_WR,
    output logic [D_BIT-1:0]        oDATA,
    output logic                    oSTART,
    input  logic                    iFHT_RDY,
    output logic                    oBUSY,
    output logic                    oDONE,
    output logic                    oERR
);

    localparam int NB  = 1 << NB_LOG2;
    localparam int IDX = A_BIT + NB_LOG2;
    localparam logic [IDX-1:0] K_LAST = '1;

    loader_state_t  state_r;
    logic [IDX-1:0] k_r;
    logic           mode_r;
    logic           ready_r;
    logic           busy_r;
    logic           start_r;
    logic           done_r;
    logic           err_r;
    logic [NB-1:0]  we_r;
    logic [A_BIT-1:0] addr_r;
    logic [D_BIT-1:0] data_r;

    logic [NB-1:0]    map_we_s;
    logic [A_BIT-1:0] map_addr_s;

    fht_bitrev_addr #(
        .A_BIT   (A_BIT),
        .NB_LOG2 (NB_LOG2)
    ) u_map (
        .k       (k_r),
        .mode    (mode_r),
        .bank_we (map_we_s),
        .addr    (map_addr_s)
    );

    // Sequencer, sample counter and the single output register stage.
    // ready/busy are set alongside each state transition so they track the state register exactly.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_r <= IDLE;
            k_r     <= '0;
            mode_r  <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            we_r    <= '0;
            addr_r  <= '0;
            data_r  <= '0;
        end else begin
            we_r    <= '0;
            start_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= iLOAD && (state_r != IDLE);
            case (state_r)
                IDLE: begin
                    if (iLOAD) begin
                        mode_r  <= iBITREV;
                        k_r     <= '0;
                        state_r <= FILL;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b1;
                    end
                end
                FILL: begin
                    if (iVALID) begin
                        we_r   <= map_we_s;
                        addr_r <= map_addr_s;
                        data_r <= iDATA;
                        if (k_r == K_LAST) begin
                            state_r <= FLUSH;
                            ready_r <= 1'b0;
                        end else begin
                            k_r <= k_r + IDX'(1);
                        end
                    end
                end
                FLUSH: begin
                    if (AUTO_START != 0) begin
                        state_r <= KICK;
                        start_r <= 1'b1;
                    end else begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                KICK: begin
                    state_r <= WAIT_LO;
                end
                // A ready left high from the previous transform must not end the wait.
                WAIT_LO: begin
                    if (!iFHT_RDY) begin
                        state_r <= WAIT_HI;
                    end
                end
                WAIT_HI: begin
                    if (iFHT_RDY) begin
                        state_r <= DONE;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign oREADY   = ready_r;
    assign oBUSY    = busy_r;
    assign oSTART   = start_r;
    assign oDONE    = done_r;
    assign oERR     = err_r;
    assign oWE      = we_r;
    assign oADDR_WR = addr_r;
    assign oDATA    = data_r;

endmodule

// File: tb/tb_fht_bank_loader.sv
// Self-checking bench for fht_bank_loader with a 4-bank, 4-word (N=16) configuration.
module tb_fht_bank_loader;

    typedef struct {
        logic [3:0]  we;
        logic [1:0]  addr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic        mode;
        int          k;
        logic [3:0]  we;
        logic [1:0]  addr;
        logic [15:0] data;
    } vec_t;

    logic        iCLK, iRESET, iLOAD, iBITREV, iVALID, iFHT_RDY;
    logic [15:0] iDATA;
    logic        oREADY, oSTART, oBUSY, oDONE, oERR;
    logic [3:0]  oWE;
    logic [1:0]  oADDR_WR;
    logic [15:0] oDATA;

    int checks = 0;
    int errors = 0;
    int start_cnt = 0;
    int done_cnt = 0;
    int wr_cnt = 0;
    int push_k = 0;
    logic cur_mode = 1'b0;
    exp_t sb[$];
    logic [3:0]  log_we[16];
    logic [1:0]  log_addr[16];
    logic [15:0] log_data[16];
    vec_t vecs[9];

    fht_bank_loader #(
        .D_BIT      (16),
        .A_BIT      (2),
        .NB_LOG2    (2),
        .AUTO_START (1)
    ) dut (
        .iCLK     (iCLK),
        .iRESET   (iRESET),
        .iLOAD    (iLOAD),
        .iBITREV  (iBITREV),
        .iDATA    (iDATA),
        .iVALID   (iVALID),
        .oREADY   (oREADY),
        .oWE      (oWE),
        .oADDR_WR (oADDR_WR),
        .oDATA    (oDATA),
        .oSTART   (oSTART),
        .iFHT_RDY (iFHT_RDY),
        .oBUSY    (oBUSY),
        .oDONE    (oDONE),
        .oERR     (oERR)
    );

    initial iCLK = 1'b0;
    always #5 iCLK = ~iCLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic mode, input int k);
        exp_t e;
        logic [3:0] kk, j;
        kk = k[3:0];
        for (int i = 0; i < 4; i++) j[i] = mode ? kk[3-i] : kk[i];
        e.we   = 4'b0001 << j[1:0];
        e.addr = j[3:2];
        e.data = 16'(100 + k);
        return e;
    endfunction

    task automatic tick();
        @(posedge iCLK);
        #1;
    endtask

    // Scoreboard producer: every accepted sample enqueues its expected bank write.
    always @(posedge iCLK) begin
        if (!iRESET && iVALID && oREADY) begin
            sb.push_back(model(cur_mode, push_k));
            push_k++;
        end
    end

    // Scoreboard consumer and pulse counters, sampled mid-cycle.
    always @(negedge iCLK) begin
        exp_t e;
        if (!iRESET) begin
            if (oSTART) start_cnt++;
            if (oDONE) done_cnt++;
            if (oWE != 4'b0000) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write actual=we%b/a%0d/d%0d expected=no_write", oWE, oADDR_WR, oDATA);
                end else begin
                    e = sb.pop_front();
                    chk("wr_we", 32'(oWE), 32'(e.we));
                    chk("wr_addr", 32'(oADDR_WR), 32'(e.addr));
                    chk("wr_data", 32'(oDATA), 32'(e.data));
                    if (wr_cnt < 16) begin
                        log_we[wr_cnt]   = oWE;
                        log_addr[wr_cnt] = oADDR_WR;
                        log_data[wr_cnt] = oDATA;
                    end
                    wr_cnt++;
                end
            end
        end
    end

    task automatic start_frame(input logic mode);
        push_k   = 0;
        wr_cnt   = 0;
        cur_mode = mode;
        iBITREV  = mode;
        iLOAD    = 1'b1;
        tick();
        iLOAD    = 1'b0;
        chk("ready_in_fill", 32'(oREADY), 32'd1);
        chk("busy_in_fill", 32'(oBUSY), 32'd1);
    endtask

    task automatic feed(input int k0, input int n, input bit gap);
        int bound;
        for (int i = k0; i < k0 + n; i++) begin
            iVALID = 1'b1;
            iDATA  = 16'(100 + i);
            bound  = 0;
            while (!oREADY && bound < 50) begin
                tick();
                bound++;
            end
            chk("ready_wait", 32'(bound < 50), 32'd1);
            tick();
            iVALID = 1'b0;
            if (gap && i != 15) tick();
        end
        iVALID = 1'b0;
    endtask

    // Entered one cycle after the last accepting edge (loader in FLUSH).
    task automatic fht_respond(input bit load_on_done);
        chk("ready_after_last", 32'(oREADY), 32'd0);
        chk("start_in_flush", 32'(oSTART), 32'd0);
        tick();
        chk("start_pulse", 32'(oSTART), 32'd1);
        tick();
        chk("start_single", 32'(oSTART), 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("done_on_stale_ready", 32'(oDONE), 32'd0);
        end
        iFHT_RDY = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("done_while_running", 32'(oDONE), 32'd0);
        end
        iFHT_RDY = 1'b1;
        tick();
        chk("done_pulse", 32'(oDONE), 32'd1);
        chk("busy_in_done", 32'(oBUSY), 32'd1);
        if (load_on_done) iLOAD = 1'b1;
        tick();
        chk("done_single", 32'(oDONE), 32'd0);
        chk("busy_after_done", 32'(oBUSY), 32'd0);
        if (load_on_done) begin
            iLOAD = 1'b0;
            chk("err_load_in_done", 32'(oERR), 32'd1);
            tick();
            chk("err_single", 32'(oERR), 32'd0);
            chk("no_frame_from_done_load", 32'(oBUSY), 32'd0);
            chk("ready_idle", 32'(oREADY), 32'd0);
        end
    endtask

    task automatic check_vecs(input logic mode);
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].mode == mode) begin
                chk($sformatf("vec%0d_we", i), 32'(log_we[vecs[i].k]), 32'(vecs[i].we));
                chk($sformatf("vec%0d_addr", i), 32'(log_addr[vecs[i].k]), 32'(vecs[i].addr));
                chk($sformatf("vec%0d_data", i), 32'(log_data[vecs[i].k]), 32'(vecs[i].data));
            end
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0, d0;
        vecs[0] = '{1'b0, 5,  4'b0010, 2'd1, 16'd105};
        vecs[1] = '{1'b0, 0,  4'b0001, 2'd0, 16'd100};
        vecs[2] = '{1'b0, 15, 4'b1000, 2'd3, 16'd115};
        vecs[3] = '{1'b1, 1,  4'b0001, 2'd2, 16'd101};
        vecs[4] = '{1'b1, 2,  4'b0001, 2'd1, 16'd102};
        vecs[5] = '{1'b1, 3,  4'b0001, 2'd3, 16'd103};
        vecs[6] = '{1'b1, 15, 4'b1000, 2'd3, 16'd115};
        vecs[7] = '{1'b1, 8,  4'b0010, 2'd0, 16'd108};
        vecs[8] = '{1'b1, 6,  4'b0100, 2'd1, 16'd106};

        iRESET = 1'b1; iLOAD = 1'b0; iBITREV = 1'b0; iVALID = 1'b0;
        iDATA = 16'd0; iFHT_RDY = 1'b1;
        repeat (3) tick();
        chk("rst_ready", 32'(oREADY), 32'd0);
        chk("rst_busy", 32'(oBUSY), 32'd0);
        chk("rst_we", 32'(oWE), 32'd0);
        chk("rst_addr", 32'(oADDR_WR), 32'd0);
        chk("rst_data", 32'(oDATA), 32'd0);
        chk("rst_start", 32'(oSTART), 32'd0);
        chk("rst_done", 32'(oDONE), 32'd0);
        chk("rst_err", 32'(oERR), 32'd0);
        iRESET = 1'b0;
        tick();
        chk("idle_ready", 32'(oREADY), 32'd0);
        chk("idle_busy", 32'(oBUSY), 32'd0);

        // Natural order, back-to-back stream.
        start_frame(1'b0);
        feed(0, 16, 1'b0);
        fht_respond(1'b0);
        chk("nat_writes", 32'(wr_cnt), 32'd16);
        chk("nat_sb_empty", 32'(sb.size()), 32'd0);
        chk("nat_starts", 32'(start_cnt), 32'd1);
        chk("nat_dones", 32'(done_cnt), 32'd1);
        check_vecs(1'b0);

        // Bit-reversed order; iLOAD arriving during DONE is flagged and ignored.
        start_frame(1'b1);
        feed(0, 16, 1'b0);
        fht_respond(1'b1);
        chk("rev_writes", 32'(wr_cnt), 32'd16);
        chk("rev_sb_empty", 32'(sb.size()), 32'd0);
        check_vecs(1'b1);

        // Valid toggling with a stray iLOAD mid-frame.
        start_frame(1'b0);
        feed(0, 8, 1'b1);
        iLOAD = 1'b1;
        tick();
        iLOAD = 1'b0;
        chk("err_load_in_fill", 32'(oERR), 32'd1);
        chk("fill_continues", 32'(oREADY), 32'd1);
        tick();
        chk("err_fill_single", 32'(oERR), 32'd0);
        feed(8, 8, 1'b1);
        fht_respond(1'b0);
        chk("gap_writes", 32'(wr_cnt), 32'd16);
        chk("gap_sb_empty", 32'(sb.size()), 32'd0);

        // Reset at k=7 aborts the frame without start or done.
        start_frame(1'b1);
        feed(0, 7, 1'b0);
        iRESET = 1'b1;
        tick();
        tick();
        chk("abort_we", 32'(oWE), 32'd0);
        chk("abort_busy", 32'(oBUSY), 32'd0);
        chk("abort_ready", 32'(oREADY), 32'd0);
        iRESET = 1'b0;
        sb.delete();
        s0 = start_cnt;
        d0 = done_cnt;
        repeat (20) tick();
        chk("abort_no_start", 32'(start_cnt), 32'(s0));
        chk("abort_no_done", 32'(done_cnt), 32'(d0));
        chk("abort_idle", 32'(oBUSY), 32'd0);

        // A fresh frame after the abort starts from k=0.
        start_frame(1'b0);
        feed(0, 16, 1'b0);
        fht_respond(1'b0);
        chk("post_abort_writes", 32'(wr_cnt), 32'd16);
        chk("post_abort_sb_empty", 32'(sb.size()), 32'd0);
        check_vecs(1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
